// File: rtl/tm1638_chip_responder.sv
// rtl/tm1638_chip_responder.sv - TM1638 chip model: serial frame decoder, display RAM, key readback
// All sio pins are oversampled in the clk domain; edges are found after the synchronizers.
module tm1638_chip_responder #(
  parameter int w_digit     = 8,
  parameter int sync_stages = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sio_clk,
  input  logic                 sio_stb,
  input  logic                 sio_data_in,
  output logic                 sio_data_out,
  output logic                 sio_data_oe,
  input  logic [7:0]           keys,
  output logic [8*w_digit-1:0] hgfedcba,
  output logic [7:0]           led,
  output logic                 display_on,
  output logic [2:0]           brightness,
  output logic                 frame_done
);

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, IGNORE} state_t;

  localparam int fw = $clog2(sync_stages + 1) + 1;

  state_t state, state_n;

  logic [sync_stages-1:0] clk_sync, stb_sync, dat_sync;
  logic                   clk_d, stb_d;
  logic                   clk_s, stb_s, dat_s;
  logic [fw-1:0]          flush_cnt;
  logic                   flush_done, armed;
  logic                   clk_rise, clk_fall, stb_rise, stb_fall;
  logic                   bit_take, byte_done;
  logic [2:0]             bit_cnt;
  logic [6:0]             shreg;
  logic [7:0]             rx_byte;
  logic [7:0]             ram [16];
  logic [3:0]             addr;
  logic                   auto_inc;
  logic [7:0]             key_shadow;
  logic [5:0]             rd_cnt;
  logic                   key_bit;

  assign clk_s = clk_sync[sync_stages-1];
  assign stb_s = stb_sync[sync_stages-1];
  assign dat_s = dat_sync[sync_stages-1];

  assign flush_done = (flush_cnt == fw'(sync_stages));
  assign clk_rise   = clk_s & ~clk_d;
  assign clk_fall   = ~clk_s & clk_d;
  assign stb_rise   = stb_s & ~stb_d;
  // After reset a frame is only accepted once stb has been seen high through the synchronizer.
  assign stb_fall   = ~stb_s & stb_d & armed;
  assign bit_take   = clk_rise & ~stb_s;
  assign byte_done  = bit_take & (bit_cnt == 3'd7);
  assign rx_byte    = {dat_s, shreg};

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      stb_sync  <= '1;
      dat_sync  <= '0;
      clk_d     <= 1'b1;
      stb_d     <= 1'b1;
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[sync_stages-2:0], sio_clk};
      stb_sync <= {stb_sync[sync_stages-2:0], sio_stb};
      dat_sync <= {dat_sync[sync_stages-2:0], sio_data_in};
      clk_d    <= clk_s;
      stb_d    <= stb_s;
      if (!flush_done) flush_cnt <= flush_cnt + 1'b1;
      if (flush_done && stb_s && stb_d) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (stb_rise) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (stb_fall) state_n = CMD;
        CMD: begin
          if (byte_done) begin
            case (rx_byte[7:6])
              2'b01:   state_n = rx_byte[1] ? READ : IGNORE;
              2'b11:   state_n = WRITE;
              default: state_n = IGNORE;
            endcase
          end
        end
        default: state_n = state;
      endcase
    end
  end

  // Key stream: byte j carries keys[j] in bit 0 and keys[j+4] in bit 4.
  always_comb begin
    key_bit = 1'b0;
    if (rd_cnt[2:0] == 3'd0)      key_bit = key_shadow[{1'b0, rd_cnt[4:3]}];
    else if (rd_cnt[2:0] == 3'd4) key_bit = key_shadow[{1'b1, rd_cnt[4:3]}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      addr         <= '0;
      auto_inc     <= 1'b1;
      key_shadow   <= '0;
      rd_cnt       <= '0;
      display_on   <= 1'b0;
      brightness   <= '0;
      sio_data_oe  <= 1'b0;
      sio_data_out <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= stb_rise;
      if (bit_take) shreg <= rx_byte[7:1];
      if (state == IDLE || stb_rise) bit_cnt <= '0;
      else if (bit_take)             bit_cnt <= bit_cnt + 1'b1;

      if (stb_rise) begin
        sio_data_oe  <= 1'b0;
        sio_data_out <= 1'b0;
      end else begin
        if (state == CMD && byte_done) begin
          key_shadow <= keys;
          rd_cnt     <= '0;
          case (rx_byte[7:6])
            2'b01: auto_inc <= ~rx_byte[2];
            2'b11: addr <= rx_byte[3:0];
            2'b10: begin
              display_on <= rx_byte[3];
              brightness <= rx_byte[2:0];
            end
            default: ;
          endcase
        end
        if (state == WRITE && byte_done) begin
          ram[addr] <= rx_byte;
          if (auto_inc) addr <= addr + 1'b1;
        end
        if (state == READ && clk_fall) begin
          sio_data_oe  <= 1'b1;
          sio_data_out <= rd_cnt[5] ? 1'b0 : key_bit;
          if (!rd_cnt[5]) rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < w_digit; i++) begin : g_digit
    assign hgfedcba[8*i +: 8] = ram[2*i];
  end

  for (genvar i = 0; i < 8; i++) begin : g_led
    assign led[i] = ram[2*i+1][0];
  end

endmodule

// File: tb/tb_tm1638_chip_responder.sv
// tb/tb_tm1638_chip_responder.sv - scoreboard bench for tm1638_chip_responder
module tb_tm1638_chip_responder;

  localparam int HP = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sio_clk = 1'b1;
  logic        sio_stb = 1'b1;
  logic        sio_data_in = 1'b0;
  logic [7:0]  keys = '0;
  logic        sio_data_out, sio_data_oe;
  logic [63:0] hgfedcba;
  logic [7:0]  led;
  logic        display_on;
  logic [2:0]  brightness;
  logic        frame_done;

  tm1638_chip_responder #(.w_digit(8), .sync_stages(2)) dut (
    .clk(clk), .rst(rst), .sio_clk(sio_clk), .sio_stb(sio_stb), .sio_data_in(sio_data_in),
    .sio_data_out(sio_data_out), .sio_data_oe(sio_data_oe), .keys(keys),
    .hgfedcba(hgfedcba), .led(led), .display_on(display_on), .brightness(brightness),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0] seg;
    logic [7:0]  led;
    logic        disp;
    logic [2:0]  br;
    bit          is_read;
    logic [31:0] rx;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  fq[$];
  logic [7:0]  mram [16];
  bit          m_auto;
  bit          m_on;
  bit [2:0]    m_br;
  logic [31:0] rx_word;
  logic        oe_ok;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) mram[i] = 8'h00;
    m_auto = 1'b1;
    m_on   = 1'b0;
    m_br   = 3'd0;
  endfunction

  // Reference: apply the complete bytes of one frame to the chip state.
  function automatic void model_frame();
    logic [7:0] c;
    int a;
    if (fq.size() == 0) return;
    c = fq[0];
    case (c[7:6])
      2'b01: m_auto = !c[2];
      2'b10: begin m_on = c[3]; m_br = c[2:0]; end
      2'b11: begin
        a = int'(c[3:0]);
        for (int k = 1; k < fq.size(); k++) begin
          mram[a] = fq[k];
          if (m_auto) a = (a + 1) % 16;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_keys(input logic [7:0] k);
    logic [31:0] w = '0;
    for (int j = 0; j < 4; j++) begin
      w[8*j]     = k[j];
      w[8*j + 4] = k[j+4];
    end
    return w;
  endfunction

  function automatic exp_t snap(input bit is_read, input logic [31:0] rx);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.seg[8*i +: 8] = mram[2*i];
      e.led[i]        = mram[2*i+1][0];
    end
    e.disp    = m_on;
    e.br      = m_br;
    e.is_read = is_read;
    e.rx      = rx;
    return e;
  endfunction

  task automatic wait_hp();
    repeat (HP) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sio_clk = 1'b0;
      sio_data_in = b[i];
      wait_hp();
      sio_clk = 1'b1;
      wait_hp();
    end
  endtask

  task automatic end_frame();
    wait_hp();
    sio_stb = 1'b1;
    wait_hp();
    wait_hp();
  endtask

  task automatic run_frame(input int partial, input logic [7:0] pval);
    sio_stb = 1'b0;
    wait_hp();
    foreach (fq[i]) send_bits(fq[i], 8);
    if (partial > 0) send_bits(pval, partial);
    model_frame();
    sb.push_back(snap(1'b0, '0));
    end_frame();
  endtask

  task automatic read_frame(input logic [7:0] cmd);
    sio_stb = 1'b0;
    wait_hp();
    send_bits(cmd, 8);
    oe_ok = (sio_data_oe === 1'b0);
    for (int k = 0; k < 32; k++) begin
      sio_clk = 1'b0;
      wait_hp();
      rx_word[k] = sio_data_out;
      if (sio_data_oe !== 1'b1) oe_ok = 1'b0;
      sio_clk = 1'b1;
      wait_hp();
    end
    m_auto = !cmd[2];
    sb.push_back(snap(1'b1, model_keys(keys)));
    end_frame();
  endtask

  always @(negedge clk) begin
    if (!rst && frame_done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame_done at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hgfedcba", hgfedcba, e.seg);
        check("led", led, e.led);
        check("display_on", display_on, e.disp);
        check("brightness", brightness, e.br);
        check("oe_after_stb", sio_data_oe, 1'b0);
        if (e.is_read) begin
          check("key_stream", rx_word, e.rx);
          check("oe_window", oe_ok, 1'b1);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog timeout");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] c;
    int n;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check("rst_seg", hgfedcba, 64'h0);
    check("rst_led", led, 8'h0);
    check("rst_ctrl", {display_on, brightness}, 4'h0);
    check("rst_sio", {sio_data_oe, sio_data_out, frame_done}, 3'b000);
    rst = 1'b0;
    wait_hp();

    fq = '{8'h40};                      run_frame(0, 0);
    fq = '{8'hC0, 8'h3F, 8'h01, 8'h06}; run_frame(0, 0);
    fq = '{8'h44};                      run_frame(0, 0);
    fq = '{8'hC4, 8'h5B, 8'h66};        run_frame(0, 0);
    fq = '{8'h40};                      run_frame(0, 0);
    fq = '{8'hCF, 8'hAA, 8'hBB};        run_frame(0, 0);
    keys = 8'b0001_0010;
    read_frame(8'h42);
    fq = '{8'h8C};                      run_frame(0, 0);
    fq = '{8'h80};                      run_frame(0, 0);
    fq = '{8'hC0, 8'h11};               run_frame(5, 8'hFF);
    fq = {};                            run_frame(0, 0);

    // Reset in the middle of a key read.
    keys = 8'($urandom);
    sio_stb = 1'b0;
    wait_hp();
    send_bits(8'h42, 8);
    for (int k = 0; k < 10; k++) begin
      sio_clk = 1'b0; wait_hp(); sio_clk = 1'b1; wait_hp();
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_oe", sio_data_oe, 1'b0);
    check("midrst_seg", hgfedcba, 64'h0);
    check("midrst_led", led, 8'h0);
    check("midrst_ctrl", {display_on, brightness}, 4'h0);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      sio_clk = 1'b0; wait_hp();
      check("postrst_oe", sio_data_oe, 1'b0);
      sio_clk = 1'b1; wait_hp();
    end
    sb.push_back(snap(1'b0, '0));
    end_frame();
    fq = '{8'hC0, 8'h12, 8'h34};        run_frame(0, 0);

    for (int f = 0; f < 30; f++) begin
      case ($urandom_range(0, 5))
        0: begin fq = '{8'h40 | 8'($urandom & 32'h3D)}; run_frame(0, 0); end
        1, 2: begin
          fq = '{8'hC0 | 8'($urandom & 32'h3F)};
          n = $urandom_range(1, 4);
          for (int k = 0; k < n; k++) fq.push_back(8'($urandom));
          run_frame(($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0, 8'($urandom));
        end
        3: begin fq = '{8'h80 | 8'($urandom & 32'h3F)}; run_frame(0, 0); end
        4: begin fq = '{8'($urandom & 32'h3F), 8'($urandom)}; run_frame(0, 0); end
        default: begin
          keys = 8'($urandom);
          c = 8'h42 | 8'($urandom & 32'h3D);
          read_frame(c);
        end
      endcase
    end

    for (int t = 0; t < 200 && sb.size() != 0; t++) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
